// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter that merges NREQ valid/ready streams into one FIFO write port.
// Optional macro FIFO_ARB_PRIORITY_EN: requester 0 wins every arbitration it requests.
module fifo_wr_arbiter #(
    parameter int DW    = 24,
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         i_valid,
    input  logic [NREQ*DW-1:0]      i_data,
    output logic [NREQ-1:0]         o_ready,
    output logic                    o_wr,
    output logic [DW-1:0]           o_wdata,
    input  logic                    i_wfull,
    output logic [$clog2(NREQ)-1:0] o_grant_id,
    output logic                    o_busy
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(BURST + 1);
    localparam logic [GW-1:0] LAST_RST = GW'(NREQ - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   w_grant_nxt;
    logic [GW-1:0]   r_last;
    logic [GW-1:0]   w_last_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            r_wr;
    logic [DW-1:0]   r_wdata;

    logic [GW-1:0]   w_rr_idx;
    logic [GW-1:0]   w_rr_pick;
    logic [GW-1:0]   w_pick;
    logic            w_any;
    logic            w_xfer;
    logic            w_acc;
    logic [DW-1:0]   w_sel_data;

    assign w_any  = |i_valid;
    assign w_xfer = (r_state == S_XFER);
    assign w_acc  = w_xfer && !i_wfull && i_valid[r_grant];

    // Walk downward so the last hit is the first valid index above last_grant.
    always_comb begin
        w_rr_idx  = '0;
        w_rr_pick = '0;
        for (int i = NREQ; i >= 1; i--) begin
            w_rr_idx = GW'((int'(r_last) + i) % NREQ);
            if (i_valid[w_rr_idx]) begin
                w_rr_pick = w_rr_idx;
            end
        end
    end

`ifdef FIFO_ARB_PRIORITY_EN
    assign w_pick = i_valid[0] ? '0 : w_rr_pick;
`else
    assign w_pick = w_rr_pick;
`endif

    always_comb begin
        o_ready    = '0;
        w_sel_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (r_grant == GW'(k)) begin
                o_ready[k] = w_xfer && !i_wfull;
                w_sel_data = i_data[k*DW +: DW];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_grant_nxt = w_pick;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_XFER;
                end
            end
            S_XFER: begin
                if (!i_wfull) begin
                    if (!i_valid[r_grant]) begin
                        w_state_nxt = S_IDLE;
                        w_last_nxt  = r_grant;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                        if (r_cnt == CNT_LAST) begin
                            w_state_nxt = S_IDLE;
                            w_last_nxt  = r_grant;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // The write port is registered: an accepted beat appears one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_last  <= LAST_RST;
            r_cnt   <= '0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wr    <= w_acc;
            if (w_acc) begin
                r_wdata <= w_sel_data;
            end
        end
    end

    assign o_wr       = r_wr;
    assign o_wdata    = r_wdata;
    assign o_grant_id = r_grant;
    assign o_busy     = w_xfer;

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 24, meaning data width per requester and per FIFO write.
REQ-002 The block SHALL have parameter NREQ, default 4, meaning number of requesters (2..16).
REQ-003 The block SHALL have parameter BURST, default 4, meaning maximum accepted beats per grant (>=1).
REQ-004 The block SHALL have port clk  input  1  sole clock, all logic rising-edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port i_valid  input  NREQ  per-requester data valid.
REQ-007 The block SHALL have port i_data  input  NREQ*DW  requester k data in bits [k*DW +: DW].
REQ-008 The block SHALL have port o_ready  output  NREQ  per-requester accept; a beat transfers when i_valid[k] & o_ready[k].
REQ-009 The block SHALL have port o_wr  output  1  FIFO write enable.
REQ-010 The block SHALL have port o_wdata  output  DW  FIFO write data.
REQ-011 The block SHALL have port i_wfull  input  1  FIFO full (registered, almost-full) flag.
REQ-012 The block SHALL have port o_grant_id  output  $clog2(NREQ)  index of current or last granted requester.
REQ-013 The block SHALL have port o_busy  output  1  high while in state XFER.

Function
REQ-014 The block SHALL implement a two-state FSM: IDLE, XFER.
REQ-015 In IDLE with any i_valid bit set, the block SHALL select the first valid requester searching upward (modulo NREQ) from last_grant+1, load o_grant_id, clear the beat counter, and enter XFER next cycle.
REQ-016 In IDLE with no i_valid bit set, the block SHALL remain in IDLE.
REQ-017 o_ready SHALL be combinational: o_ready[k] = (state==XFER) & (k==o_grant_id) & ~i_wfull; all other bits 0.
REQ-018 Each accepted beat at cycle t SHALL produce o_wr=1 with o_wdata = that beat's data at cycle t+1 (registered, latency 1); o_wr SHALL be 0 in every other cycle.
REQ-019 In XFER with i_wfull=1, the block SHALL hold state, counter and grant, and accept nothing.
REQ-020 In XFER the beat counter SHALL increment per accepted beat; the beat that makes count equal BURST SHALL return the FSM to IDLE next cycle.
REQ-021 In XFER with i_wfull=0 and i_valid[o_grant_id]=0, the block SHALL return to IDLE next cycle (grant released early).
REQ-022 On every XFER->IDLE transition, last_grant SHALL be set to o_grant_id; o_grant_id SHALL hold its value while in IDLE.
REQ-023 Minimum latency from i_valid rising in IDLE to o_wr SHALL be 2 cycles; one idle bubble cycle SHALL separate consecutive grants.
REQ-024 With simultaneous requests, the block SHALL guarantee each requester a grant within NREQ arbitrations (round-robin fairness).

Reset
REQ-025 Asserting rst SHALL immediately force state=IDLE, o_wr=0, o_wdata=0, o_grant_id=0, beat counter=0, last_grant=NREQ-1, o_busy=0, hence o_ready=0.
REQ-026 Reset asserted mid-burst SHALL abort the burst; no o_wr SHALL occur in the cycle after rst deasserts unless a beat is accepted then, and the first post-reset grant SHALL go to the lowest-index valid requester.

Configuration
REQ-027 With macro FIFO_ARB_PRIORITY_EN defined, the block SHALL grant requester 0 in IDLE whenever i_valid[0]=1, overriding round-robin; other requesters SHALL use round-robin as in REQ-015.
REQ-028 Without FIFO_ARB_PRIORITY_EN, the block SHALL use pure round-robin for all requesters.

Verification
REQ-029 The bench SHALL cover: reset release, i_valid=4'b0001, requester 0 sends 0xA1,0xA2 then drops valid -> o_wr carries 0xA1,0xA2 on consecutive cycles, FSM returns to IDLE, o_grant_id=0.
REQ-030 The bench SHALL cover: i_valid=4'b1111 held, all sending continuously, BURST=4 -> grants 0,1,2,3,0 in order, exactly 4 writes per grant, one bubble between grants.
REQ-031 The bench SHALL cover: i_wfull=1 for 3 cycles mid-burst after 2 beats -> o_ready=0 and o_wr=0 during stall, then remaining 2 beats written, no data lost or duplicated.
REQ-032 The bench SHALL cover: rst pulsed after beat 1 of a 4-beat burst from requester 2 -> outputs reset immediately, next grant goes to lowest valid index.
REQ-033 The bench SHALL cover: FIFO_ARB_PRIORITY_EN defined, i_valid=4'b1011 held -> requester 0 granted at every arbitration; undefined -> grants 0,1,3,0.
